// File: rtl/timer_core.sv
// timer_core: timer register file with a prescaled 32-bit counter, compare match, overflow and W1C status.
module timer_core #(
  parameter int NUM_REGS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REGS-1:0]      w_enable,
  input  logic [NUM_REGS-1:0]      r_enable,
  input  logic [31:0]              w_data,
  output logic [NUM_REGS*32-1:0]   read_data,
  output logic                     irq
);
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic        en, tick, hit, top;
  logic        unused_r;

  assign unused_r = ^r_enable;

  always_comb begin
    en = ctrl_q[0];
    tick = en && (pre_cnt_q == prescale_q);
    hit = count_q == compare_q;
    top = &count_q;
    ctrl_d = w_enable[0] ? w_data[3:0] : ctrl_q;
    // one-shot stop overrides a simultaneous CTRL write re-arming EN
    if (tick && hit && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    prescale_d = w_enable[1] ? w_data[15:0] : prescale_q;
    compare_d = w_enable[2] ? w_data : compare_q;
    count_d = w_enable[3] ? w_data :
              !tick       ? count_q :
              hit         ? (ctrl_q[1] ? 32'd0 : count_q) :
                            count_q + 32'd1;
    status_d = (status_q & ~(w_enable[4] ? w_data[1:0] : 2'b00)) | {tick & !hit & top, tick & hit};
    pre_cnt_d = (tick || w_enable[3] || w_enable[1] || (w_enable[0] && w_data[0] && !en)) ? 16'd0 :
                en ? pre_cnt_q + 16'd1 : pre_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      prescale_q <= '0;
      compare_q <= 32'hFFFF_FFFF;
      count_q <= '0;
      status_q <= '0;
      pre_cnt_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q <= compare_d;
      count_q <= count_d;
      status_q <= status_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign read_data[0*32+:32] = {28'd0, ctrl_q};
  assign read_data[1*32+:32] = {16'd0, prescale_q};
  assign read_data[2*32+:32] = compare_q;
  assign read_data[3*32+:32] = count_q;
  assign read_data[4*32+:32] = {30'd0, status_q};
  assign irq = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
endmodule

// File: tb/tb_timer_core.sv
// tb_timer_core: directed vector table for the timer scenarios plus randomized traffic against a reference model.
module tb_timer_core;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [4:0]   w_enable = '0;
  logic [4:0]   r_enable = '0;
  logic [31:0]  w_data = '0;
  logic [159:0] read_data;
  logic         irq;
  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [31:0]  m_reg [5];
  logic [15:0]  m_pre;

  typedef struct {
    int          wi;
    logic [31:0] wd;
    int          idle;
    logic [31:0] cnt;
    logic [3:0]  ctrl;
    logic [1:0]  st;
    logic        irq;
  } vec_t;
  vec_t vt[$];

  timer_core #(.NUM_REGS(5)) dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .r_enable(r_enable),
    .w_data(w_data), .read_data(read_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    else pass_cnt++;
  endtask

  // Reference: registers as a plain array, evolved one clock at a time from the written rules.
  task automatic model_step(input int wi, input logic [31:0] wd, input logic r);
    logic [31:0] n_reg [5];
    logic [15:0] n_pre;
    logic        on, tk;
    if (r) begin
      m_reg = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
      m_pre = 16'd0;
      return;
    end
    n_reg = m_reg;
    on = m_reg[0][0];
    tk = on && ({16'd0, m_pre} == m_reg[1]);
    n_pre = !on ? m_pre : tk ? 16'd0 : m_pre + 16'd1;
    case (wi)
      0: begin n_reg[0] = wd & 32'hF; if (!on && wd[0]) n_pre = 16'd0; end
      1: begin n_reg[1] = wd & 32'hFFFF; n_pre = 16'd0; end
      2: n_reg[2] = wd;
      3: begin n_reg[3] = wd; n_pre = 16'd0; end
      4: n_reg[4] = m_reg[4] & ~(wd & 32'h3);
      default: ;
    endcase
    if (tk) begin
      if (m_reg[3] == m_reg[2]) begin
        n_reg[4] |= 32'h1;
        if (m_reg[0][1]) begin if (wi != 3) n_reg[3] = 32'd0; end
        else n_reg[0] &= ~32'h1;
      end else if (m_reg[3] == 32'hFFFF_FFFF) begin
        n_reg[4] |= 32'h2;
        if (wi != 3) n_reg[3] = 32'd0;
      end else if (wi != 3) n_reg[3] = m_reg[3] + 32'd1;
    end
    m_reg = n_reg;
    m_pre = n_pre;
  endtask

  task automatic cyc(input int wi, input logic [31:0] wd, input logic r);
    rst = r;
    w_enable = (wi >= 0) ? 5'(1 << wi) : 5'd0;
    w_data = wd;
    r_enable = 5'($urandom_range(0, 31));
    model_step(wi, wd, r);
    @(posedge clk);
    #1;
    rst = 1'b0;
    w_enable = '0;
  endtask

  initial begin
    vt.push_back('{1, 32'd3, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd1, 40, 32'd10, 4'h1, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 3, 32'd10, 4'h1, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 1, 32'd11, 4'h1, 2'd0, 1'b0});
    vt.push_back('{0, 32'd0, 0, 32'd11, 4'h0, 2'd0, 1'b0});
    vt.push_back('{1, 32'd0, 0, 32'd11, 4'h0, 2'd0, 1'b0});
    vt.push_back('{3, 32'd0, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{2, 32'd5, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd7, 0, 32'd0, 4'h7, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 4, 32'd4, 4'h7, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 1, 32'd5, 4'h7, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 1, 32'd0, 4'h7, 2'd1, 1'b1});
    vt.push_back('{4, 32'd1, 0, 32'd1, 4'h7, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 4, 32'd5, 4'h7, 2'd0, 1'b0});
    vt.push_back('{4, 32'd3, 0, 32'd0, 4'h7, 2'd1, 1'b1});
    vt.push_back('{0, 32'd0, 0, 32'd1, 4'h0, 2'd1, 1'b0});
    vt.push_back('{4, 32'd3, 0, 32'd1, 4'h0, 2'd0, 1'b0});
    vt.push_back('{3, 32'd0, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{2, 32'd3, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd1, 0, 32'd0, 4'h1, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 5, 32'd3, 4'h0, 2'd1, 1'b0});
    vt.push_back('{4, 32'd1, 0, 32'd3, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd1, 0, 32'd3, 4'h1, 2'd0, 1'b0});
    vt.push_back('{0, 32'd1, 0, 32'd3, 4'h0, 2'd1, 1'b0});
    vt.push_back('{4, 32'd1, 0, 32'd3, 4'h0, 2'd0, 1'b0});
    vt.push_back('{3, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 4'h0, 2'd0, 1'b0});
    vt.push_back('{2, 32'd0, 0, 32'hFFFF_FFFE, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd11, 2, 32'd0, 4'hB, 2'd2, 1'b1});
    vt.push_back('{0, 32'd0, 0, 32'd0, 4'h0, 2'd3, 1'b0});
    vt.push_back('{4, 32'd3, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{2, 32'hFFFF_FFFF, 0, 32'd0, 4'h0, 2'd0, 1'b0});
    vt.push_back('{0, 32'd1, 0, 32'd0, 4'h1, 2'd0, 1'b0});
    vt.push_back('{3, 32'h100, 0, 32'h100, 4'h1, 2'd0, 1'b0});
    vt.push_back('{-1, 32'd0, 1, 32'h101, 4'h1, 2'd0, 1'b0});
    vt.push_back('{0, 32'd0, 0, 32'h102, 4'h0, 2'd0, 1'b0});

    cyc(-1, 0, 1'b1);
    cyc(-1, 0, 1'b1);
    chk("reset_ctrl", read_data[0+:32], 32'd0);
    chk("reset_prescale", read_data[32+:32], 32'd0);
    chk("reset_compare", read_data[64+:32], 32'hFFFF_FFFF);
    chk("reset_count", read_data[96+:32], 32'd0);
    chk("reset_status", read_data[128+:32], 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    foreach (vt[k]) begin
      if (vt[k].wi >= 0) cyc(vt[k].wi, vt[k].wd, 1'b0);
      repeat (vt[k].idle) cyc(-1, 0, 1'b0);
      chk($sformatf("vec%0d_count", k), read_data[96+:32], vt[k].cnt);
      chk($sformatf("vec%0d_ctrl", k), read_data[0+:32], {28'd0, vt[k].ctrl});
      chk($sformatf("vec%0d_status", k), read_data[128+:32], {30'd0, vt[k].st});
      chk($sformatf("vec%0d_irq", k), {31'd0, irq}, {31'd0, vt[k].irq});
    end

    for (int n = 0; n < 3000; n++) begin
      int          wi;
      logic [31:0] wd;
      logic        r;
      r = ($urandom_range(0, 299) == 0);
      wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      case (wi)
        0: wd = $urandom_range(0, 15) | (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'd0);
        1: wd = $urandom_range(0, 3) | (($urandom_range(0, 3) == 0) ? 32'hABCD_0000 : 32'd0);
        2: wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
        3: wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 12));
        default: wd = $urandom;
      endcase
      cyc(wi, wd, r);
      for (int i = 0; i < 5; i++) chk($sformatf("rand%0d_word%0d", n, i), read_data[i*32+:32], m_reg[i]);
      chk($sformatf("rand%0d_irq", n), {31'd0, irq},
          {31'd0, (m_reg[4][0] & m_reg[0][2]) | (m_reg[4][1] & m_reg[0][3])});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
